dmem_wait_ctrl: RTL and testbench

Word-organised data-memory controller sitting directly downstream of the write-back/write-allocate data cache. Accepts single-cycle read/write request pulses on the `dmem_*` bus and holds them internally. Performs the access against an internal byte-strobed SRAM array after a fixed, parameterised latency, and returns a one-cycle `dmem_ready_o` pulse with read data. Sticky error reporting flags protocol violations from the cache side.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_sram_array.sv | 28 ++
 rtl/dmem_wait_ctrl.sv | 157 +++++++++++++++
 tb/tb_dmem_wait_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_wait_ctrl data-memory controller.
// The request struct is sized for the widest supported configuration; the
// controller zero-extends narrower requests into it and slices them back out.
package dmem_pkg;

    localparam int DMEM_LATENCY_DEF = 4;
    localparam int DMEM_MAX_AW      = 64;
    localparam int DMEM_MAX_DW      = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic [DMEM_MAX_AW-1:0]   addr;
        logic [DMEM_MAX_DW-1:0]   wdata;
        logic [DMEM_MAX_DW/8-1:0] wstrb;
        logic                     is_write;
    } dmem_req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// DEPTH x DATA_WIDTH storage: synchronous byte-strobed write, combinational read.
// Storage has no reset; contents survive a controller reset.
module dmem_sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write of the enabled strobes only
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Fixed-latency data-memory controller behind the data cache.
// Optional feature: define DMEM_PENDQ_EN for a one-entry pending slot that
// holds a request arriving while busy; without it such requests are dropped
// and flagged in err_o.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = DMEM_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    input  logic                    dmem_write_i,
    input  logic                    dmem_read_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic                    busy_o,
    output logic                    err_o,
    input  logic                    clear_err_i
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    dmem_state_e state, state_next;
    logic [7:0]  cnt, cnt_next;
    dmem_req_t   cur, cur_next, in_req, start_req;
    logic        req_in, both, start, drop, err_next;
    logic [DATA_WIDTH-1:0] arr_rdata;

`ifdef DMEM_PENDQ_EN
    dmem_req_t pend, pend_next;
    logic      pend_vld, pend_vld_next;
`endif

    assign req_in = dmem_read_i | dmem_write_i;
    assign both   = dmem_read_i & dmem_write_i;

    // Pack the bus request; a simultaneous read+write is taken as a write
    always_comb begin
        in_req          = '0;
        in_req.addr     = DMEM_MAX_AW'(dmem_addr_i);
        in_req.wdata    = DMEM_MAX_DW'(dmem_wdata_i);
        in_req.wstrb    = (DMEM_MAX_DW/8)'(dmem_wstrb_i);
        in_req.is_write = dmem_write_i;
    end

    // Next-state, counter, request latch and pending-slot logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cur_next   = cur;
        start      = 1'b0;
        start_req  = in_req;
        drop       = 1'b0;
`ifdef DMEM_PENDQ_EN
        pend_next     = pend;
        pend_vld_next = pend_vld;
`endif
        case (state)
            IDLE: begin
`ifdef DMEM_PENDQ_EN
                // A held request goes first; a new one in the same cycle has nowhere to go
                if (pend_vld) begin
                    start         = 1'b1;
                    start_req     = pend;
                    pend_vld_next = 1'b0;
                    drop          = req_in;
                end else if (req_in) begin
                    start = 1'b1;
                end
`else
                start = req_in;
`endif
            end
            WAIT: begin
                if (cnt != 8'd0) cnt_next = cnt - 8'd1;
                if (cnt <= 8'd1) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state != IDLE && req_in) begin
`ifdef DMEM_PENDQ_EN
            if (pend_vld) begin
                drop = 1'b1;
            end else begin
                pend_vld_next = 1'b1;
                pend_next     = in_req;
            end
`else
            drop = 1'b1;
`endif
        end

        if (start) begin
            cur_next   = start_req;
            cnt_next   = CNT_LOAD;
            state_next = (LATENCY == 1) ? DONE : WAIT;
        end

        // A fresh error outranks a clear in the same cycle
        err_next = err_o;
        if (clear_err_i)  err_next = 1'b0;
        if (both || drop) err_next = 1'b1;
    end

    // State, counter, latched request and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= '0;
            err_o <= 1'b0;
`ifdef DMEM_PENDQ_EN
            pend     <= '0;
            pend_vld <= 1'b0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cur   <= cur_next;
            err_o <= err_next;
`ifdef DMEM_PENDQ_EN
            pend     <= pend_next;
            pend_vld <= pend_vld_next;
`endif
        end
    end

    dmem_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (state == DONE && cur.is_write),
        .idx   (cur.addr[IDX_W+1:2]),
        .wdata (cur.wdata[DATA_WIDTH-1:0]),
        .wstrb (cur.wstrb[DATA_WIDTH/8-1:0]),
        .rdata (arr_rdata)
    );

    assign dmem_ready_o = (state == DONE);
    assign busy_o       = (state != IDLE);
    assign dmem_rdata_o = (state == DONE && !cur.is_write) ? arr_rdata : '0;

    // Address bits outside the word index are ignored by design
    logic unused_bits;
    assign unused_bits = ^{cur.addr, cur.wdata, cur.wstrb};

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed self-checking bench for dmem_wait_ctrl (LATENCY = 4, DEPTH = 1024).
module tb_dmem_wait_ctrl;

    localparam int AW = 32, DW = 32, DEPTH = 1024, LAT = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          write = 1'b0, read = 1'b0, clear_err = 1'b0;
    logic [DW-1:0] rdata;
    logic          ready, busy, err;

    always #5 clk = ~clk;

    dmem_wait_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
        .dmem_wstrb_i(wstrb), .dmem_write_i(write), .dmem_read_i(read),
        .dmem_rdata_o(rdata), .dmem_ready_o(ready), .busy_o(busy), .err_o(err),
        .clear_err_i(clear_err)
    );

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Pulse one request, wait (bounded) for ready, return latency and data seen
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic wr, input logic rd, output int lat, output logic [31:0] q,
                          output logic busy1);
        addr = a; wdata = d; wstrb = s; write = wr; read = rd;
        tick();
        write = 1'b0; read = 1'b0;
        busy1 = busy;
        lat = 0; q = '0;
        for (int k = 1; k <= 20; k++) begin
            if (ready) begin lat = k; q = rdata; break; end
            tick();
        end
        tick();
    endtask

    initial begin
        int          lat, nrdy, r1, r2;
        logic [31:0] q, q2;
        logic        b1;

        tick(); tick();
        check("rst_ready", ready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy",  busy, 0);
        check("rst_err",   err, 0);
        rst_n = 1'b1;
        tick();

        access(32'h40, 32'hDEADBEEF, 4'hF, 1, 0, lat, q, b1);
        check("wr_lat", lat, LAT);
        check("wr_busy", b1, 1);
        check("wr_rdata_zero", q, 0);
        check("idle_busy", busy, 0);
        access(32'h40, 0, 0, 0, 1, lat, q, b1);
        check("rd_lat", lat, LAT);
        check("rd_data", q, 32'hDEADBEEF);

        access(32'h40, 32'h000000AA, 4'h1, 1, 0, lat, q, b1);
        access(32'h40, 0, 0, 0, 1, lat, q, b1);
        check("strb_data", q, 32'hDEADBEAA);

        access(32'h40 + DEPTH*4, 0, 0, 0, 1, lat, q, b1);
        check("alias_data", q, 32'hDEADBEAA);
        check("alias_err", err, 0);

        access(32'h40, 32'hFFFFFFFF, 4'h0, 1, 0, lat, q, b1);
        check("strb0_lat", lat, LAT);
        access(32'h40, 0, 0, 0, 1, lat, q, b1);
        check("strb0_data", q, 32'hDEADBEAA);

        access(32'h80, 32'h12345678, 4'hF, 1, 1, lat, q, b1);
        check("both_lat", lat, LAT);
        check("both_err", err, 1);
        access(32'h80, 0, 0, 0, 1, lat, q, b1);
        check("both_data", q, 32'h12345678);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        check("clear_err", err, 0);

        // clear coinciding with a new error: error wins
        addr = 32'h80; wdata = 32'h12345678; wstrb = 4'hF; write = 1; read = 1; clear_err = 1;
        tick();
        write = 0; read = 0; clear_err = 0;
        check("clear_vs_err", err, 1);
        tick(); tick(); tick(); tick();
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        check("clear_err2", err, 0);

        // second read two cycles after the first
        addr = 32'h40; read = 1'b1;
        tick();
        read = 1'b0;
        nrdy = 0; r1 = 0; r2 = 0; q2 = '0;
        for (int k = 1; k <= 12; k++) begin
            if (ready) begin
                nrdy++;
                if (nrdy == 1) r1 = k;
                else begin r2 = k; q2 = rdata; end
            end
            if (k == 2) read = 1'b1;
            if (k == 3) read = 1'b0;
            tick();
        end
        check("b2b_first_at", r1, 4);
`ifdef DMEM_PENDQ_EN
        check("b2b_count", nrdy, 2);
        check("b2b_second_at", r2, 9);
        check("b2b_second_data", q2, 32'hDEADBEAA);
        check("b2b_err", err, 0);
`else
        check("b2b_count", nrdy, 1);
        check("b2b_err", err, 1);
`endif
        clear_err = 1'b1; tick(); clear_err = 1'b0;

        // reset in the middle of a write
        access(32'hC0, 32'h11112222, 4'hF, 1, 0, lat, q, b1);
        addr = 32'hC0; wdata = 32'h55555555; wstrb = 4'hF; write = 1'b1;
        tick();
        write = 1'b0;
        tick();
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_err",   err, 0);
        nrdy = 0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (ready) nrdy++;
            tick();
        end
        check("mid_rst_no_ready", nrdy, 0);
        access(32'hC0, 0, 0, 0, 1, lat, q, b1);
        check("mid_rst_old_data", q, 32'h11112222);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
